// File: rtl/music_pkg.sv
// Shared types and constants for the MUSIC DOA sweep sequencer.
package music_pkg;

  localparam int THETA_W    = 8;
  localparam int LUT_ADDR_W = THETA_W + 2;
  localparam int STEER_W    = 8;
  localparam int EIG_W      = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EVD,
    S_SELECT,
    S_FETCH,
    S_ISSUE,
    S_WAIT_SPEC,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/noise_subspace_select.sv
// Combinational finder of the two smallest of four signed eigenvalues.
// Ties resolve to the lower index for both idx1 and idx2.
module noise_subspace_select
  import music_pkg::*;
(
  input  logic signed [EIG_W-1:0] d0,
  input  logic signed [EIG_W-1:0] d1,
  input  logic signed [EIG_W-1:0] d2,
  input  logic signed [EIG_W-1:0] d3,
  output logic        [1:0]       idx1,
  output logic        [1:0]       idx2
);

  logic signed [EIG_W-1:0] d [4];

  always_comb begin
    d[0] = d0;
    d[1] = d1;
    d[2] = d2;
    d[3] = d3;

    idx1 = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (d[i] < d[idx1]) idx1 = 2'(i);
    end

    // Seed with the first index that is not idx1, then scan in ascending order.
    idx2 = (idx1 == 2'd0) ? 2'd1 : 2'd0;
    for (int i = 1; i < 4; i++) begin
      if ((2'(i) != idx1) && (d[i] < d[idx2])) idx2 = 2'(i);
    end
  end

endmodule

// File: rtl/music_sweep_sequencer.sv
// Top-level MUSIC DOA sequencer: EVD handshake, noise-vector select, theta sweep, peak tracking.
// Optional watchdog in WAIT_SPEC enabled by defining MUSIC_SEQ_TIMEOUT_EN.
module music_sweep_sequencer #(
  parameter int THETA_MAX   = 180,
  parameter int THETA_W     = music_pkg::THETA_W,
  parameter int SPEC_W      = 64,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cov_av,
  input  logic                           evd_av,
  input  logic signed [music_pkg::EIG_W-1:0]   d0,
  input  logic signed [music_pkg::EIG_W-1:0]   d1,
  input  logic signed [music_pkg::EIG_W-1:0]   d2,
  input  logic signed [music_pkg::EIG_W-1:0]   d3,
  input  logic signed [music_pkg::STEER_W-1:0] lut_data,
  input  logic                           spec_av,
  input  logic        [SPEC_W-1:0]       spec_val,
  output logic        [THETA_W+1:0]      lut_addr,
  output logic signed [music_pkg::STEER_W-1:0] steer0,
  output logic signed [music_pkg::STEER_W-1:0] steer1,
  output logic signed [music_pkg::STEER_W-1:0] steer2,
  output logic signed [music_pkg::STEER_W-1:0] steer3,
  output logic                           steer_av,
  output logic        [1:0]              noise_idx1,
  output logic        [1:0]              noise_idx2,
  output logic                           busy,
  output logic                           sweep_done,
  output logic        [THETA_W-1:0]      peak_theta,
  output logic        [SPEC_W-1:0]       peak_val,
  output logic                           timeout_err
);

  import music_pkg::*;

  seq_state_t          state;
  seq_state_t          state_nxt;
  logic [THETA_W-1:0]  theta;
  logic [2:0]          fetch_cnt;
  logic [SPEC_W-1:0]   run_min;
  logic [THETA_W-1:0]  run_theta;
  logic [1:0]          sel_idx1;
  logic [1:0]          sel_idx2;
  logic                at_last;
  logic                to_hit;

  assign at_last  = (theta == THETA_W'(THETA_MAX));
  assign busy     = (state != S_IDLE);
  assign lut_addr = (state == S_FETCH) ? {theta, fetch_cnt[1:0]} : '0;

  noise_subspace_select u_select (
    .d0   (d0),
    .d1   (d1),
    .d2   (d2),
    .d3   (d3),
    .idx1 (sel_idx1),
    .idx2 (sel_idx2)
  );

`ifdef MUSIC_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  // A result arriving on the last allowed cycle still wins over the watchdog.
  assign to_hit = (state == S_WAIT_SPEC) && !spec_av &&
                  (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_WAIT_SPEC) to_cnt <= to_cnt + 1'b1;
      else                      to_cnt <= '0;
      if (to_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    steer_av   = 1'b0;
    sweep_done = 1'b0;
    case (state)
      S_IDLE:      if (cov_av) state_nxt = S_WAIT_EVD;
      S_WAIT_EVD:  if (evd_av) state_nxt = S_SELECT;
      S_SELECT:    state_nxt = S_FETCH;
      S_FETCH:     if (fetch_cnt == 3'd4) state_nxt = S_ISSUE;
      S_ISSUE: begin
        steer_av  = 1'b1;
        state_nxt = S_WAIT_SPEC;
      end
      S_WAIT_SPEC: begin
        if (spec_av)     state_nxt = at_last ? S_DONE : S_FETCH;
        else if (to_hit) state_nxt = S_IDLE;
      end
      S_DONE: begin
        sweep_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      theta      <= '0;
      fetch_cnt  <= '0;
      run_min    <= '1;
      run_theta  <= '0;
      steer0     <= '0;
      steer1     <= '0;
      steer2     <= '0;
      steer3     <= '0;
      noise_idx1 <= 2'd0;
      noise_idx2 <= 2'd1;
      peak_theta <= '0;
      peak_val   <= '1;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          theta     <= '0;
          fetch_cnt <= '0;
        end
        S_SELECT: begin
          noise_idx1 <= sel_idx1;
          noise_idx2 <= sel_idx2;
          theta      <= '0;
          fetch_cnt  <= '0;
          run_min    <= '1;
          run_theta  <= '0;
        end
        S_FETCH: begin
          // LUT word for element k arrives one cycle after its address.
          fetch_cnt <= fetch_cnt + 3'd1;
          case (fetch_cnt)
            3'd1:    steer0 <= lut_data;
            3'd2:    steer1 <= lut_data;
            3'd3:    steer2 <= lut_data;
            3'd4:    steer3 <= lut_data;
            default: ;
          endcase
        end
        S_ISSUE: fetch_cnt <= '0;
        S_WAIT_SPEC: begin
          if (spec_av) begin
            if (spec_val < run_min) begin
              run_min   <= spec_val;
              run_theta <= theta;
            end
            if (!at_last) theta <= theta + 1'b1;
          end
        end
        S_DONE: begin
          peak_theta <= run_theta;
          peak_val   <= run_min;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_music_sweep_sequencer.sv
// Directed bench for music_sweep_sequencer: eigen-select table, full sweeps with LUT and
// spectrum models, cov_av during a sweep, mid-sweep reset and (with the macro) the watchdog.
module tb_music_sweep_sequencer;
  import music_pkg::*;

  localparam int SPEC_W   = 64;
  localparam int SPEC_LAT = 2;
  localparam int SWEEP_BUDGET = 4000;
  localparam logic [SPEC_W-1:0] ALL_ONES = '1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   cov_av, evd_av, spec_av;
  logic signed [31:0]     d0, d1, d2, d3;
  logic signed [7:0]      lut_data;
  logic [SPEC_W-1:0]      spec_val;
  logic [LUT_ADDR_W-1:0]  lut_addr;
  logic signed [7:0]      steer0, steer1, steer2, steer3;
  logic                   steer_av, busy, sweep_done, timeout_err;
  logic [1:0]             noise_idx1, noise_idx2;
  logic [7:0]             peak_theta;
  logic [SPEC_W-1:0]      peak_val;

  music_sweep_sequencer dut (
    .clk(clk), .rst(rst), .cov_av(cov_av), .evd_av(evd_av),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .lut_data(lut_data), .spec_av(spec_av), .spec_val(spec_val),
    .lut_addr(lut_addr), .steer0(steer0), .steer1(steer1), .steer2(steer2), .steer3(steer3),
    .steer_av(steer_av), .noise_idx1(noise_idx1), .noise_idx2(noise_idx2),
    .busy(busy), .sweep_done(sweep_done), .peak_theta(peak_theta), .peak_val(peak_val),
    .timeout_err(timeout_err)
  );

  // clock / global bound
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // models
  function automatic logic [7:0] lut_model(input logic [9:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [63:0] spec_model(input int mode, input int th);
    case (mode)
      0:       return 64'((th > 60) ? (th - 60) : (60 - th)) + 64'd10;
      1:       return 64'd100;
      default: return 64'(200 - th);
    endcase
  endfunction

  // LUT + spectrum responder and steer scoreboard, all on the falling edge
  int          mode = 0;
  int          withhold_theta = -1;
  int          steer_cnt = 0;
  int          done_cnt = 0;
  int          resp_wait = 0;
  int          resp_theta = 0;
  logic [9:0]  prev_addr = '0;
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    logic [9:0]  a;
    logic [31:0] e;
    spec_av  = 1'b0;
    spec_val = '0;
    if (resp_wait > 0) begin
      resp_wait--;
      if (resp_wait == 0) begin
        spec_av  = 1'b1;
        spec_val = spec_model(mode, resp_theta);
      end
    end
    if (steer_av) begin
      for (int k = 0; k < 4; k++) begin
        a = {8'(steer_cnt), 2'(k)};
        e[8*k +: 8] = lut_model(a);
      end
      exp_q.push_back(e);
      check("steer_weights", {steer3, steer2, steer1, steer0}, exp_q.pop_front());
      resp_theta = steer_cnt;
      if (steer_cnt != withhold_theta) resp_wait = SPEC_LAT;
      steer_cnt++;
    end
    if (sweep_done) done_cnt++;
    lut_data  = lut_model(prev_addr);
    prev_addr = lut_addr;
  end

  // driver tasks
  task automatic start_sweep(input logic [31:0] a0, a1, a2, a3);
    d0 = a0; d1 = a1; d2 = a2; d3 = a3;
    steer_cnt = 0;
    done_cnt  = 0;
    resp_wait = 0;
    cov_av = 1'b1;
    @(negedge clk);
    cov_av = 1'b0;
    evd_av = 1'b1;
    @(negedge clk);
    evd_av = 1'b0;
  endtask

  task automatic wait_steer(input int n, input string name);
    int c;
    for (c = 0; c < SWEEP_BUDGET; c++) begin
      @(negedge clk);
      if (steer_cnt >= n) break;
    end
    check(name, c < SWEEP_BUDGET, 1);
  endtask

  task automatic wait_done(input string name);
    int c;
    for (c = 0; c < SWEEP_BUDGET; c++) begin
      @(negedge clk);
      if (done_cnt > 0) break;
    end
    check(name, c < SWEEP_BUDGET, 1);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},       busy, 0);
    check({tag, "_steer_av"},   steer_av, 0);
    check({tag, "_sweep_done"}, sweep_done, 0);
    check({tag, "_lut_addr"},   lut_addr, 0);
    check({tag, "_steer"},      {steer3, steer2, steer1, steer0}, 0);
    check({tag, "_idx1"},       noise_idx1, 0);
    check({tag, "_idx2"},       noise_idx2, 1);
    check({tag, "_peak_theta"}, peak_theta, 0);
    check({tag, "_peak_val"},   peak_val, ALL_ONES);
    check({tag, "_timeout"},    timeout_err, 0);
  endtask

  task automatic check_sweep(input string tag, input int pt, input logic [63:0] pv,
                             input logic [1:0] i1, input logic [1:0] i2);
    check({tag, "_peak_theta"}, peak_theta, 64'(pt));
    check({tag, "_peak_val"},   peak_val, pv);
    check({tag, "_steer_cnt"},  steer_cnt, 181);
    check({tag, "_done_cnt"},   done_cnt, 1);
    check({tag, "_idx1"},       noise_idx1, i1);
    check({tag, "_idx2"},       noise_idx2, i2);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_timeout"},    timeout_err, 0);
  endtask

  typedef struct {
    logic [31:0] v0, v1, v2, v3;
    logic [1:0]  e1, e2;
  } sel_vec_t;

  sel_vec_t vecs [8];

  initial begin
    cov_av = 1'b0; evd_av = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("por_release");

    // eigenvalue selection table: {d0,d1,d2,d3} -> idx1, idx2
    vecs[0] = '{32'sd5, -32'sd3, 32'sd7, -32'sd3, 2'd1, 2'd3};
    vecs[1] = '{32'sd1, 32'sd2, 32'sd3, 32'sd4, 2'd0, 2'd1};
    vecs[2] = '{32'sd4, 32'sd3, 32'sd2, 32'sd1, 2'd3, 2'd2};
    vecs[3] = '{32'sd0, 32'sd0, 32'sd0, 32'sd0, 2'd0, 2'd1};
    vecs[4] = '{-32'sd1, 32'sd5, -32'sd10, 32'sd7, 2'd2, 2'd0};
    vecs[5] = '{32'sd7, 32'sd7, -32'sd2, 32'sd7, 2'd2, 2'd0};
    vecs[6] = '{32'h7fff_ffff, 32'h8000_0000, 32'd0, 32'd1, 2'd1, 2'd2};
    vecs[7] = '{32'sd3, -32'sd5, -32'sd5, -32'sd5, 2'd1, 2'd2};

    for (int i = 0; i < 8; i++) begin
      start_sweep(vecs[i].v0, vecs[i].v1, vecs[i].v2, vecs[i].v3);
      @(negedge clk);
      check($sformatf("sel%0d_busy", i), busy, 1);
      check($sformatf("sel%0d_idx1", i), noise_idx1, vecs[i].e1);
      check($sformatf("sel%0d_idx2", i), noise_idx2, vecs[i].e2);
      rst = 1'b1;
      #1;
      check_reset_outputs($sformatf("sel%0d_rst", i));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
    end

    // V-shaped spectrum, minimum at theta 60
    mode = 0;
    start_sweep(32'sd5, -32'sd3, 32'sd7, -32'sd3);
    wait_done("vshape_done_seen");
    check_sweep("vshape", 60, 64'd10, 2'd1, 2'd3);

    // flat spectrum: earliest theta keeps the peak
    mode = 1;
    start_sweep(32'sd1, 32'sd2, 32'sd3, 32'sd4);
    wait_done("flat_done_seen");
    check_sweep("flat", 0, 64'd100, 2'd0, 2'd1);

    // descending spectrum, minimum at the last angle; cov_av pulsed mid-sweep
    mode = 2;
    start_sweep(32'sd4, 32'sd3, 32'sd2, 32'sd1);
    wait_steer(31, "inject_reach_theta30");
    @(negedge clk);
    cov_av = 1'b1;
    @(negedge clk);
    cov_av = 1'b0;
    wait_done("inject_done_seen");
    check_sweep("inject", 180, 64'd20, 2'd3, 2'd2);

    // asynchronous reset in the middle of the sweep
    mode = 0;
    start_sweep(32'sd5, -32'sd3, 32'sd7, -32'sd3);
    wait_steer(91, "midrst_reach_theta90");
    @(negedge clk);
    rst = 1'b1;
    resp_wait = 0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_done_cnt", done_cnt, 0);
    check("midrst_idle", busy, 0);
    start_sweep(32'sd5, -32'sd3, 32'sd7, -32'sd3);
    wait_done("after_rst_done_seen");
    check_sweep("after_rst", 60, 64'd10, 2'd1, 2'd3);

`ifdef MUSIC_SEQ_TIMEOUT_EN
    // spectrum result withheld at theta 5: watchdog aborts the sweep
    begin
      int c;
      mode = 0;
      withhold_theta = 5;
      start_sweep(32'sd5, -32'sd3, 32'sd7, -32'sd3);
      wait_steer(6, "to_reach_theta5");
      for (c = 0; c < 1500; c++) begin
        if (!busy) break;
        @(negedge clk);
      end
      check("to_abort_window", (c >= 1015) && (c <= 1030), 1);
      check("to_err", timeout_err, 1);
      repeat (10) @(negedge clk);
      check("to_err_sticky", timeout_err, 1);
      check("to_no_done", done_cnt, 0);
      check("to_peak_theta_kept", peak_theta, 60);
      check("to_peak_val_kept", peak_val, 64'd10);
      check("to_steer_cnt", steer_cnt, 6);
      withhold_theta = -1;
    end
`else
    check("no_watchdog_err", timeout_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
